capture_ctrl: RTL and testbench

Sample-capture sequencer for the oscilloscope acquisition path. It sits between the ADC channel-0 sample stream and port A of the 15-bit-address dual-port sample RAM. It generates write enables and addresses, detects a level/edge trigger, and keeps a fixed pre-trigger history. After the trigger it writes a fixed number of post-trigger samples, then freezes the buffer and tells the display read side where the frame starts.

---
 rtl/capture_ctrl.sv | 170 +++++++++++++++++
 tb/tb_capture_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// Oscilloscope sample-capture sequencer: writes ADC samples into a circular RAM,
// keeps PRETRIG history, triggers on a level crossing and freezes after POSTTRIG.
// Optional timeout trigger: define AUTO_TRIG_EN.
module capture_ctrl #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 12,
  parameter int PRETRIG      = 1024,
  parameter int POSTTRIG     = 8192,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] rd_base,
  output logic [2:0]        state,
  output logic              done,
  output logic              trig_forced
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

`ifdef AUTO_TRIG_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  localparam int CNT_MAX0 = (PRETRIG > POSTTRIG) ? PRETRIG : POSTTRIG;
  localparam int CNT_MAX  = (CNT_MAX0 > AUTO_TIMEOUT) ? CNT_MAX0 : AUTO_TIMEOUT;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'((PRETRIG  > 0) ? PRETRIG  - 1 : 0);
  localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'((POSTTRIG > 0) ? POSTTRIG - 1 : 0);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'((AUTO_TIMEOUT > 0) ? AUTO_TIMEOUT - 1 : 0);
  localparam logic [ADDR_W-1:0] PRE_MOD   = ADDR_W'(PRETRIG);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_ok_q, prev_ok_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   rd_base_q, rd_base_d;
  logic                forced_q, forced_d;

  logic accept, level_hit, auto_fire, trig_hit;

  assign accept = sample_valid && !arm &&
                  (state_q == ST_PRE || state_q == ST_WAIT || state_q == ST_POST);

  assign level_hit = prev_ok_q && (trig_rising ?
                     (prev_q < trig_level && sample >= trig_level) :
                     (prev_q > trig_level && sample <= trig_level));

  // A natural crossing wins over the timeout, so trig_forced only flags true timeouts.
  assign auto_fire = AUTO_EN && (cnt_q == TO_LAST) && !level_hit;
  assign trig_hit  = accept && (state_q == ST_WAIT) && (level_hit || auto_fire);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      cnt_q       <= '0;
      prev_q      <= '0;
      prev_ok_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      trig_addr_q <= '0;
      rd_base_q   <= '0;
      forced_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      prev_ok_q   <= prev_ok_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      trig_addr_q <= trig_addr_d;
      rd_base_q   <= rd_base_d;
      forced_q    <= forced_d;
    end
  end

  // NOTE: each always_comb assigns a default to every target first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = (PRETRIG == 0) ? ST_WAIT : ST_PRE;
    end else if (accept) begin
      unique case (state_q)
        ST_PRE:  if (cnt_q == PRE_LAST) state_d = ST_WAIT;
        ST_WAIT: if (trig_hit) state_d = (POSTTRIG == 0) ? ST_DONE : ST_POST;
        ST_POST: if (cnt_q == POST_LAST) state_d = ST_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    prev_ok_d   = prev_ok_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    trig_addr_d = trig_addr_q;
    rd_base_d   = rd_base_q;
    forced_d    = forced_q;
    if (arm) begin
      wptr_d    = '0;
      cnt_d     = '0;
      prev_ok_d = 1'b0;
      forced_d  = 1'b0;
    end else if (accept) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wptr_q;
      wr_data_d = sample;
      wptr_d    = wptr_q + 1'b1;
      prev_d    = sample;
      prev_ok_d = 1'b1;
      unique case (state_q)
        ST_PRE:  cnt_d = (cnt_q == PRE_LAST) ? '0 : cnt_q + 1'b1;
        ST_WAIT: begin
          if (trig_hit) begin
            trig_addr_d = wptr_q;
            rd_base_d   = wptr_q - PRE_MOD;
            cnt_d       = '0;
            forced_d    = auto_fire;
          end else if (AUTO_EN) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_POST: cnt_d = cnt_q + 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign trig_addr   = trig_addr_q;
  assign rd_base     = rd_base_q;
  assign state       = state_q;
  assign done        = (state_q == ST_DONE);
  assign trig_forced = forced_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: directed scenarios plus random stimulus
// compared every cycle against a write-index based reference model.
module tb_capture_ctrl;

  localparam int ADDR_W       = 4;
  localparam int DATA_W       = 12;
  localparam int PRETRIG      = 4;
  localparam int POSTTRIG     = 8;
  localparam int AUTO_TIMEOUT = 5;
  localparam int DEPTH        = 1 << ADDR_W;

  logic              CLOCK = 1'b0;
  logic              RESET;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              arm;
  logic [DATA_W-1:0] trig_level;
  logic              trig_rising;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] rd_base;
  logic [2:0]        state;
  logic              done;
  logic              trig_forced;

  capture_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRETRIG(PRETRIG),
    .POSTTRIG(POSTTRIG), .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .sample(sample), .sample_valid(sample_valid),
    .arm(arm), .trig_level(trig_level), .trig_rising(trig_rising),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .trig_addr(trig_addr),
    .rd_base(rd_base), .state(state), .done(done), .trig_forced(trig_forced)
  );

  always #5 CLOCK = ~CLOCK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: everything derives from the count of writes since arm.
  bit m_armed, m_prev_ok, m_forced, m_wr_en;
  int m_n, m_trig_idx, m_wait_n, m_prev;
  int m_trig_addr, m_rd_base, m_wr_addr, m_wr_data;

  int pulses, last_addr;

  function automatic int m_phase();
    if (!m_armed) return 0;
    if (m_trig_idx >= 0) return (m_n - m_trig_idx - 1 >= POSTTRIG) ? 4 : 3;
    return (m_n >= PRETRIG) ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_prev_ok = 0; m_forced = 0; m_wr_en = 0;
    m_n = 0; m_trig_idx = -1; m_wait_n = 0; m_prev = 0;
    m_trig_addr = 0; m_rd_base = 0; m_wr_addr = 0; m_wr_data = 0;
  endtask

  task automatic model_update(input bit v, input bit a, input int s);
    int  ph;
    bit  hit;
    ph = m_phase();
    m_wr_en = 0;
    if (a) begin
      m_armed = 1; m_n = 0; m_trig_idx = -1; m_wait_n = 0;
      m_forced = 0; m_prev_ok = 0;
    end else if (v && ph >= 1 && ph <= 3) begin
      m_wr_en   = 1;
      m_wr_addr = m_n % DEPTH;
      m_wr_data = s;
      if (ph == 2) begin
        m_wait_n++;
        if (trig_rising) hit = m_prev_ok && m_prev < int'(trig_level) && s >= int'(trig_level);
        else             hit = m_prev_ok && m_prev > int'(trig_level) && s <= int'(trig_level);
`ifdef AUTO_TRIG_EN
        if (!hit && m_wait_n == AUTO_TIMEOUT) begin
          hit = 1;
          m_forced = 1;
        end
`endif
        if (hit) begin
          m_trig_idx  = m_n;
          m_trig_addr = m_n % DEPTH;
          m_rd_base   = ((m_n - PRETRIG) % DEPTH + DEPTH) % DEPTH;
        end
      end
      m_prev = s; m_prev_ok = 1; m_n++;
    end
  endtask

  task automatic compare_all();
    int ph;
    ph = m_phase();
    check("state", state, ph);
    check("wr_en", wr_en, m_wr_en);
    check("done", done, ph == 4);
    check("trig_forced", trig_forced, m_forced);
    if (m_wr_en) begin
      check("wr_addr", wr_addr, m_wr_addr);
      check("wr_data", wr_data, m_wr_data);
    end
    if (ph >= 3) begin
      check("trig_addr", trig_addr, m_trig_addr);
      check("rd_base", rd_base, m_rd_base);
    end
  endtask

  task automatic step(input bit v, input bit a, input int s);
    sample_valid = v;
    arm          = a;
    sample       = DATA_W'(s);
    @(posedge CLOCK);
    model_update(v, a, s);
    #1;
    compare_all();
    if (wr_en) begin
      pulses++;
      last_addr = wr_addr;
    end
  endtask

  task automatic run_seq(input int seq[$]);
    foreach (seq[i]) step(1'b1, 1'b0, seq[i]);
  endtask

  task automatic async_reset();
    @(posedge CLOCK);
    #3;
    RESET = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_rd_base", rd_base, 0);
    @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; sample = '0; sample_valid = 1'b0; arm = 1'b0;
    trig_level = 12'd250; trig_rising = 1'b1;
    model_reset();
    pulses = 0; last_addr = -1;
    #1;
    compare_all();
    check("rst_trig_addr0", trig_addr, 0);
    check("rst_rd_base0", rd_base, 0);
    @(negedge CLOCK);
    RESET = 1'b0;

    // Rising trigger with an ignored crossing during PRE and a wrapped final write
    step(1'b1, 1'b0, 77);
    step(1'b0, 1'b1, 0);
    pulses = 0;
    run_seq('{0, 100, 200, 300, 300, 300, 0, 0, 500});
    check("rise_trig_addr", trig_addr, 8);
    check("rise_rd_base", rd_base, 4);
    run_seq('{1, 2, 3, 4, 5, 6, 7, 8});
    check("rise_done", done, 1);
    check("rise_last_addr", last_addr, 0);
    run_seq('{9, 9, 9});
    check("rise_pulses", pulses, 17);

    // Falling trigger
    trig_rising = 1'b0;
    step(1'b0, 1'b1, 0);
    run_seq('{400, 400, 400, 400, 400, 400, 100});
    check("fall_trig_addr", trig_addr, 6);
    check("fall_rd_base", rd_base, 2);
    run_seq('{50, 50, 50, 50, 50, 50, 50, 50});
    check("fall_done", done, 1);
    check("fall_last_addr", last_addr, 14);

    // Re-arm mid-POST with a coincident sample
    trig_rising = 1'b1;
    step(1'b0, 1'b1, 0);
    run_seq('{0, 0, 0, 0, 0, 300, 10, 20});
    step(1'b1, 1'b1, 777);
    check("rearm_no_write", wr_en, 0);
    check("rearm_state", state, 1);
    check("rearm_done", done, 0);
    step(1'b1, 1'b0, 5);
    check("rearm_addr", wr_addr, 0);

    // Asynchronous reset mid-POST, then no writes until armed
    run_seq('{5, 5, 5, 0, 400, 1});
    check("pre_reset_post", state, 3);
    async_reset();
    run_seq('{1, 300, 2, 500});
    check("idle_no_wr", wr_en, 0);

    // PRE/WAIT boundary
    step(1'b0, 1'b1, 0);
    run_seq('{0, 0, 0, 0, 300});
    check("bnd_trig_at4", trig_addr, 4);
    step(1'b0, 1'b1, 0);
    run_seq('{0, 0, 0, 300, 0, 300});
    check("bnd_trig_at5", trig_addr, 5);

    // Constant input: timeout trigger only when enabled
    step(1'b0, 1'b1, 0);
`ifdef AUTO_TRIG_EN
    run_seq('{100, 100, 100, 100, 100, 100, 100, 100, 100});
    check("auto_trig_addr", trig_addr, 8);
    check("auto_forced", trig_forced, 1);
    check("auto_state", state, 3);
`else
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 100);
    check("noauto_wait", state, 2);
    check("noauto_forced", trig_forced, 0);
`endif

    // Randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      bit a, v;
      a = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (a) begin
        trig_level  = DATA_W'($urandom_range(500, 3500));
        trig_rising = 1'($urandom_range(0, 1));
      end
      step(v, a, $urandom_range(0, 4095));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
